// File: rtl/gc_stream_receiver.sv
// Evaluator-side receiver for the tagged garbling stream.
// Captures the AES key, forwards input labels and garbled-table rows to the
// evaluator memories via registered write ports, latches output masks and
// enforces stream ordering with a sticky first-cause error.
module gc_stream_receiver #(
  parameter int unsigned S = 20,
  parameter int unsigned K = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     tag,
  input  logic [S-1:0]   cid,
  input  logic [S-1:0]   index0,
  input  logic [S-1:0]   index1,
  input  logic [K-1:0]   data0,
  input  logic [K-1:0]   data1,
  output logic [K-1:0]   aes_key,
  output logic           key_valid,
  output logic           il_wr_en_0,
  output logic           il_wr_en_1,
  output logic [S-1:0]   il_wr_addr_0,
  output logic [S-1:0]   il_wr_addr_1,
  output logic [K-1:0]   il_wr_data_0,
  output logic [K-1:0]   il_wr_data_1,
  output logic           gt_wr_en,
  output logic [S-1:0]   gt_wr_addr_0,
  output logic [S-1:0]   gt_wr_addr_1,
  output logic [K-1:0]   gt_wr_data_0,
  output logic [K-1:0]   gt_wr_data_1,
  output logic [S-1:0]   gt_count,
  output logic [2*K-1:0] mask,
  output logic           frame_done,
  output logic [S-1:0]   exp_cid,
  output logic           err,
  output logic [2:0]     err_code
);

  localparam logic [2:0] TagIdle   = 3'b000;
  localparam logic [2:0] TagKeys   = 3'b001;
  localparam logic [2:0] TagGt     = 3'b010;
  localparam logic [2:0] TagMasks  = 3'b011;
  localparam logic [2:0] TagIll    = 3'b100;
  localparam logic [2:0] TagLabel2 = 3'b111;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrIllegal = 3'd1;
  localparam logic [2:0] ErrOrder   = 3'd2;
  localparam logic [2:0] ErrGtAddr  = 3'd3;
  localparam logic [2:0] ErrCid     = 3'd4;

  localparam logic [S-1:0] OneS = {{(S-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StConst, StStream, StError} state_e;

  state_e     state_q, state_d;
  logic [2:0] err_cause;
  logic       gt_order_ok;
  logic       const_idx_ok;
  logic       key_cap, il0_wr, il1_wr, gt_wr, mask_cap;

  // Expected GT row pair is (2*gt_count, 2*gt_count+1), both truncated to S bits.
  assign gt_order_ok  = (index0 == {gt_count[S-2:0], 1'b0}) && (index1 == index0 + OneS);
  assign const_idx_ok = (index0 == '0) && (index1 == OneS);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and error classification for the beat on the inputs.
  always_comb begin
    state_d   = state_q;
    err_cause = ErrNone;
    unique case (state_q)
      StIdle: begin
        if (tag == TagKeys) begin
          state_d = StConst;
        end else if (tag == TagIll) begin
          err_cause = ErrIllegal;
        end else if (tag != TagIdle) begin
          err_cause = ErrOrder;
        end
      end
      StConst: begin
        if (tag == TagLabel2 && const_idx_ok) begin
          state_d = StStream;
        end else if (tag == TagIll) begin
          err_cause = ErrIllegal;
        end else if (tag != TagIdle) begin
          err_cause = ErrOrder;
        end
      end
      StStream: begin
        // cid mismatch outranks every tag-specific check.
        if (tag != TagIdle) begin
          if (cid != exp_cid) begin
            err_cause = ErrCid;
          end else if (tag == TagIll) begin
            err_cause = ErrIllegal;
          end else if (tag == TagKeys) begin
            err_cause = ErrOrder;
          end else if (tag == TagGt && !gt_order_ok) begin
            err_cause = ErrGtAddr;
          end
        end
      end
      StError: ;
      default: ;
    endcase
    if (err_cause != ErrNone) begin
      state_d = StError;
    end
  end

  // Decode the actions of an accepted beat; an offending beat does nothing.
  always_comb begin
    key_cap  = 1'b0;
    il0_wr   = 1'b0;
    il1_wr   = 1'b0;
    gt_wr    = 1'b0;
    mask_cap = 1'b0;
    if (err_cause == ErrNone) begin
      unique case (state_q)
        StIdle:   key_cap = (tag == TagKeys);
        StConst: begin
          il0_wr = (tag == TagLabel2);
          il1_wr = (tag == TagLabel2);
        end
        StStream: begin
          il0_wr   = tag[2] & tag[0];
          il1_wr   = tag[2] & tag[1];
          gt_wr    = (tag == TagGt);
          mask_cap = (tag == TagMasks);
        end
        StError:  ;
        default:  ;
      endcase
    end
  end

  // Registered write ports, captured key/mask, counters and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_key      <= '0;
      key_valid    <= 1'b0;
      il_wr_en_0   <= 1'b0;
      il_wr_en_1   <= 1'b0;
      il_wr_addr_0 <= '0;
      il_wr_addr_1 <= '0;
      il_wr_data_0 <= '0;
      il_wr_data_1 <= '0;
      gt_wr_en     <= 1'b0;
      gt_wr_addr_0 <= '0;
      gt_wr_addr_1 <= '0;
      gt_wr_data_0 <= '0;
      gt_wr_data_1 <= '0;
      gt_count     <= '0;
      mask         <= '0;
      frame_done   <= 1'b0;
      exp_cid      <= '0;
      err          <= 1'b0;
      err_code     <= '0;
    end else begin
      il_wr_en_0 <= il0_wr;
      il_wr_en_1 <= il1_wr;
      gt_wr_en   <= gt_wr;
      frame_done <= mask_cap;
      if (key_cap) begin
        // data0 carries R, which the evaluator must never hold.
        aes_key   <= data1;
        key_valid <= 1'b1;
      end
      if (il0_wr) begin
        il_wr_addr_0 <= index0;
        il_wr_data_0 <= data0;
      end
      if (il1_wr) begin
        il_wr_addr_1 <= index1;
        il_wr_data_1 <= data1;
      end
      if (gt_wr) begin
        gt_wr_addr_0 <= index0;
        gt_wr_addr_1 <= index1;
        gt_wr_data_0 <= data0;
        gt_wr_data_1 <= data1;
      end
      if (mask_cap) begin
        mask     <= {data0, data1};
        gt_count <= '0;
        exp_cid  <= exp_cid + OneS;
      end else if (gt_wr) begin
        gt_count <= gt_count + OneS;
      end
      if (err_cause != ErrNone) begin
        err      <= 1'b1;
        err_code <= err_cause;
      end
    end
  end

endmodule

// File: tb/tb_gc_stream_receiver.sv
// Self-checking bench for gc_stream_receiver: directed protocol scenarios
// followed by randomized streams, checked against a rule-level model.
module tb_gc_stream_receiver;

  localparam int unsigned S = 20;
  localparam int unsigned K = 128;

  logic           clk, rst;
  logic [2:0]     tag;
  logic [S-1:0]   cid, index0, index1;
  logic [K-1:0]   data0, data1;
  logic [K-1:0]   aes_key;
  logic           key_valid;
  logic           il_wr_en_0, il_wr_en_1;
  logic [S-1:0]   il_wr_addr_0, il_wr_addr_1;
  logic [K-1:0]   il_wr_data_0, il_wr_data_1;
  logic           gt_wr_en;
  logic [S-1:0]   gt_wr_addr_0, gt_wr_addr_1;
  logic [K-1:0]   gt_wr_data_0, gt_wr_data_1;
  logic [S-1:0]   gt_count;
  logic [2*K-1:0] mask;
  logic           frame_done;
  logic [S-1:0]   exp_cid;
  logic           err;
  logic [2:0]     err_code;

  gc_stream_receiver #(.S(S), .K(K)) dut (
    .clk(clk), .rst(rst), .tag(tag), .cid(cid), .index0(index0), .index1(index1),
    .data0(data0), .data1(data1), .aes_key(aes_key), .key_valid(key_valid),
    .il_wr_en_0(il_wr_en_0), .il_wr_en_1(il_wr_en_1),
    .il_wr_addr_0(il_wr_addr_0), .il_wr_addr_1(il_wr_addr_1),
    .il_wr_data_0(il_wr_data_0), .il_wr_data_1(il_wr_data_1),
    .gt_wr_en(gt_wr_en), .gt_wr_addr_0(gt_wr_addr_0), .gt_wr_addr_1(gt_wr_addr_1),
    .gt_wr_data_0(gt_wr_data_0), .gt_wr_data_1(gt_wr_data_1),
    .gt_count(gt_count), .mask(mask), .frame_done(frame_done), .exp_cid(exp_cid),
    .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = waiting for key, 1 = waiting for constants,
  // 2 = streaming, 3 = halted on error.
  int             m_phase;
  logic [K-1:0]   m_key;
  logic           m_kv, m_err;
  logic [2:0]     m_code;
  logic [S-1:0]   m_gtc, m_cid;
  logic [2*K-1:0] m_mask;
  logic           e_il0, e_il1, e_gt, e_fd;
  logic [S-1:0]   e_il0_a, e_il1_a, e_gt0_a, e_gt1_a;
  logic [K-1:0]   e_il0_d, e_il1_d, e_gt0_d, e_gt1_d;

  task automatic chk(input string name, input logic [2*K-1:0] obs, input logic [2*K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_key = '0; m_kv = 0; m_err = 0; m_code = 0;
    m_gtc = '0; m_cid = '0; m_mask = '0;
    e_il0 = 0; e_il1 = 0; e_gt = 0; e_fd = 0;
  endtask

  task automatic model_step(input logic [2:0] t, input logic [S-1:0] c, i0, i1,
                            input logic [K-1:0] d0, d1);
    int code;
    logic [S-1:0] want0, want1;
    code = 0;
    e_il0 = 0; e_il1 = 0; e_gt = 0; e_fd = 0;
    want0 = m_gtc + m_gtc;
    want1 = want0 + 1;
    if (m_phase == 3 || t == 3'd0) begin
      // nothing happens
    end else if (m_phase == 2 && c != m_cid) begin
      code = 4;
    end else if (t == 3'd4) begin
      code = 1;
    end else if (m_phase == 0) begin
      if (t == 3'd1) begin m_key = d1; m_kv = 1; m_phase = 1; end
      else code = 2;
    end else if (m_phase == 1) begin
      if (t == 3'd7 && i0 == 0 && i1 == 1) begin
        e_il0 = 1; e_il0_a = i0; e_il0_d = d0;
        e_il1 = 1; e_il1_a = i1; e_il1_d = d1;
        m_phase = 2;
      end else code = 2;
    end else begin
      case (t)
        3'd1: code = 2;
        3'd2: begin
          if (i0 == want0 && i1 == want1) begin
            e_gt = 1; e_gt0_a = i0; e_gt1_a = i1; e_gt0_d = d0; e_gt1_d = d1;
            m_gtc = m_gtc + 1;
          end else code = 3;
        end
        3'd3: begin
          m_mask = {d0, d1}; e_fd = 1; m_gtc = '0; m_cid = m_cid + 1;
        end
        default: begin
          if (t[0]) begin e_il0 = 1; e_il0_a = i0; e_il0_d = d0; end
          if (t[1]) begin e_il1 = 1; e_il1_a = i1; e_il1_d = d1; end
        end
      endcase
    end
    if (code != 0) begin
      m_err = 1; m_code = 3'(code); m_phase = 3;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".il_en0"}, 256'(il_wr_en_0), 256'(e_il0));
    chk({ctx, ".il_en1"}, 256'(il_wr_en_1), 256'(e_il1));
    chk({ctx, ".gt_en"}, 256'(gt_wr_en), 256'(e_gt));
    chk({ctx, ".frame_done"}, 256'(frame_done), 256'(e_fd));
    chk({ctx, ".aes_key"}, 256'(aes_key), 256'(m_key));
    chk({ctx, ".key_valid"}, 256'(key_valid), 256'(m_kv));
    chk({ctx, ".gt_count"}, 256'(gt_count), 256'(m_gtc));
    chk({ctx, ".exp_cid"}, 256'(exp_cid), 256'(m_cid));
    chk({ctx, ".mask"}, mask, m_mask);
    chk({ctx, ".err"}, 256'(err), 256'(m_err));
    chk({ctx, ".err_code"}, 256'(err_code), 256'(m_code));
    if (e_il0) begin
      chk({ctx, ".il_addr0"}, 256'(il_wr_addr_0), 256'(e_il0_a));
      chk({ctx, ".il_data0"}, 256'(il_wr_data_0), 256'(e_il0_d));
    end
    if (e_il1) begin
      chk({ctx, ".il_addr1"}, 256'(il_wr_addr_1), 256'(e_il1_a));
      chk({ctx, ".il_data1"}, 256'(il_wr_data_1), 256'(e_il1_d));
    end
    if (e_gt) begin
      chk({ctx, ".gt_addr0"}, 256'(gt_wr_addr_0), 256'(e_gt0_a));
      chk({ctx, ".gt_addr1"}, 256'(gt_wr_addr_1), 256'(e_gt1_a));
      chk({ctx, ".gt_data0"}, 256'(gt_wr_data_0), 256'(e_gt0_d));
      chk({ctx, ".gt_data1"}, 256'(gt_wr_data_1), 256'(e_gt1_d));
    end
  endtask

  task automatic beat(input logic [2:0] t, input logic [S-1:0] c, i0, i1,
                      input logic [K-1:0] d0, d1, input string ctx);
    tag = t; cid = c; index0 = i0; index1 = i1; data0 = d0; data1 = d1;
    @(posedge clk); #1;
    model_step(t, c, i0, i1, d0, d1);
    tag = 3'd0;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    rst = 1'b1; tag = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all(ctx);
  endtask

  function automatic logic [K-1:0] rnd_k();
    logic [K-1:0] v;
    for (int i = 0; i < K / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [S-1:0] rnd_s();
    logic [31:0] v;
    v = $urandom();
    return v[S-1:0];
  endfunction

  task automatic start_stream(input string ctx);
    beat(3'b001, rnd_s(), rnd_s(), rnd_s(), rnd_k(), rnd_k(), {ctx, ".keys"});
    beat(3'b111, rnd_s(), 0, 1, rnd_k(), rnd_k(), {ctx, ".const"});
  endtask

  logic [K-1:0] r_val, a5;
  logic [S-1:0] g0;
  int r;

  initial begin
    rst = 1'b1; tag = 0; cid = 0; index0 = 0; index1 = 0; data0 = 0; data1 = 0;
    a5 = {(K / 8){8'hA5}};

    // Reset and idle stream.
    do_reset("reset");
    for (int i = 0; i < 3; i++) beat(3'b000, rnd_s(), rnd_s(), rnd_s(), rnd_k(), rnd_k(), "idle");

    // Keys then constants.
    r_val = rnd_k();
    beat(3'b001, 0, 0, 0, r_val, a5, "keys");
    beat(3'b000, 0, 0, 0, 0, 0, "keys_gap");
    beat(3'b111, 0, 0, 1, rnd_k(), rnd_k(), "const");

    // One full circuit cycle, masks beat right after the last GT beat.
    beat(3'b110, 0, 0, 7, rnd_k(), rnd_k(), "label7");
    beat(3'b010, 0, 0, 1, rnd_k(), rnd_k(), "gt01");
    beat(3'b010, 0, 2, 3, rnd_k(), rnd_k(), "gt23");
    beat(3'b010, 0, 4, 5, rnd_k(), rnd_k(), "gt45");
    beat(3'b011, 0, 0, 0, rnd_k(), rnd_k(), "masks");
    beat(3'b000, 0, 0, 0, 0, 0, "post_masks");

    // GT order violation after two tables.
    do_reset("reset2");
    start_stream("gtord");
    beat(3'b010, 0, 0, 1, rnd_k(), rnd_k(), "gtord.gt0");
    beat(3'b010, 0, 2, 3, rnd_k(), rnd_k(), "gtord.gt1");
    beat(3'b010, 0, 6, 7, rnd_k(), rnd_k(), "gtord.bad");
    beat(3'b111, 0, 9, 10, rnd_k(), rnd_k(), "gtord.after_label");
    beat(3'b011, 0, 0, 0, rnd_k(), rnd_k(), "gtord.after_masks");

    // cid mismatch in the second circuit cycle.
    do_reset("reset3");
    start_stream("cid");
    beat(3'b011, 0, 0, 0, rnd_k(), rnd_k(), "cid.masks");
    beat(3'b010, 0, 0, 1, rnd_k(), rnd_k(), "cid.bad");

    // Illegal tag in a fresh run.
    do_reset("reset4");
    beat(3'b100, 0, 0, 0, rnd_k(), rnd_k(), "illegal");

    // Asynchronous reset with a GT write enable pending.
    do_reset("reset5");
    start_stream("arst");
    beat(3'b010, 0, 0, 1, rnd_k(), rnd_k(), "arst.gt0");
    beat(3'b010, 0, 2, 3, rnd_k(), rnd_k(), "arst.gt1");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst.async");
    #3 rst = 1'b0;
    start_stream("arst.restart");

    // Randomized streams with occasional protocol faults.
    for (int n = 0; n < 400; n++) begin
      if (m_phase != 2) begin
        do_reset("rnd.reset");
        start_stream("rnd");
      end
      r = $urandom_range(0, 99);
      g0 = m_gtc + m_gtc;
      if (r < 20) beat(3'b000, rnd_s(), rnd_s(), rnd_s(), rnd_k(), rnd_k(), "rnd.idle");
      else if (r < 45) beat(3'(5 + $urandom_range(0, 2)), m_cid, rnd_s(), rnd_s(),
                            rnd_k(), rnd_k(), "rnd.label");
      else if (r < 75) beat(3'b010, m_cid, g0, g0 + 1, rnd_k(), rnd_k(), "rnd.gt");
      else if (r < 85) beat(3'b011, m_cid, rnd_s(), rnd_s(), rnd_k(), rnd_k(), "rnd.masks");
      else if (r < 88) beat(3'b010, m_cid, g0 + 2, g0 + 3, rnd_k(), rnd_k(), "rnd.badgt");
      else if (r < 90) beat(3'b010, m_cid + 1, g0, g0 + 1, rnd_k(), rnd_k(), "rnd.badcid");
      else if (r < 92) beat(3'b100, m_cid, rnd_s(), rnd_s(), rnd_k(), rnd_k(), "rnd.illegal");
      else if (r < 94) beat(3'b001, m_cid, rnd_s(), rnd_s(), rnd_k(), rnd_k(), "rnd.rekey");
      else beat(3'b000, rnd_s(), rnd_s(), rnd_s(), rnd_k(), rnd_k(), "rnd.idle2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gc_stream_receiver.md
# gc_stream_receiver

Evaluator-side receiver for the tagged garbling stream produced by the garbler core. It consumes one beat per cycle with no backpressure, captures the AES key while discarding R, and writes input labels and garbled-table rows into the evaluator memories through registered write ports. It also latches output masks once per clock cycle of the garbled circuit and checks stream ordering, raising a sticky error on any protocol violation.

## Interface

**Parameters**
- S, 20, index and cycle-id width
- K, 128, label width

**Ports**
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- tag  in  3  beat type: 000 idle, 001 keys, 010 garbled table, 011 masks, 101/110/111 input label(s), 100 illegal
- cid  in  S  sender circuit-cycle id
- index0, index1  in  S  beat addresses
- data0, data1  in  K  beat payloads
- aes_key  out  K  captured AES key (data1 of the keys beat)
- key_valid  out  1  high once the key is captured
- il_wr_en_0, il_wr_en_1  out  1  input-label write enables
- il_wr_addr_0, il_wr_addr_1  out  S  input-label addresses
- il_wr_data_0, il_wr_data_1  out  K  input-label data
- gt_wr_en  out  1  garbled-table write (both rows)
- gt_wr_addr_0, gt_wr_addr_1  out  S  row addresses
- gt_wr_data_0, gt_wr_data_1  out  K  row data
- gt_count  out  S  garbled tables received in the current cycle
- mask  out  2K  output mask, {data0, data1}
- frame_done  out  1  one-cycle pulse when a masks beat is accepted
- exp_cid  out  S  expected cid
- err  out  1  sticky error flag
- err_code  out  3  first error cause

## Operation

- **States:** IDLE, CONST, STREAM, ERROR.
- **IDLE**
  - tag 001: aes_key <= data1, key_valid <= 1, go to CONST. data0 (R) is never stored.
  - tag 000: ignored.
  - Any other tag: error, code 2.
- **CONST**
  - tag 000: ignored.
  - tag 111 with index0 = 0 and index1 = 1: write both constant labels, go to STREAM.
  - Anything else: error, code 2.
- **STREAM**
  - tag 101/110/111: tag[0] writes data0 to index0, tag[1] writes data1 to index1. Addresses pass through unchanged; the +2 constant offset is already applied by the sender.
  - tag 010: requires index0 = 2*gt_count and index1 = index0+1. On match, gt_wr_en = 1 and gt_count increments. Mismatch is error, code 3.
  - tag 011: mask <= {data0, data1}, frame_done pulses, gt_count <= 0, exp_cid increments.
  - tag 001: error, code 2.
- **cid check:** in STREAM, any non-idle beat whose cid differs from exp_cid is error, code 4. The cid check has priority over the tag-specific checks.
- **Illegal tag:** tag 100 in any state except ERROR is error, code 1.
- **ERROR**
  - err = 1; err_code holds the first cause.
  - No further writes: all write enables 0, frame_done 0.
  - The only exit is rst.
- **Arithmetic:** gt_count and exp_cid are S-bit and wrap modulo 2^S with no error. The GT address check uses the S-bit product 2*gt_count (truncated).

## Timing

- All outputs are registered. A beat accepted at edge n appears on the write ports, aes_key, mask, and frame_done after edge n+1. Write enables are high for exactly one cycle per beat.
- Counters update on the same edge as the corresponding write output.
- There is no backpressure. Back-to-back beats of any legal mix are accepted every cycle; idle (000) cycles may be interleaved freely.
- The error check runs on the same edge as the beat. The offending beat produces no write, and err rises one cycle after it.
- **Reset values:** all enables, key_valid, frame_done, and err = 0; aes_key, mask, gt_count, exp_cid, err_code, and all addresses/data = 0; state IDLE.
- Reset asserted mid-stream clears everything immediately (asynchronously), including any pending write enable.
- The masks beat and the final GT beat may be adjacent cycles. The GT write uses the pre-clear gt_count.

## Test plan

1. **Reset:** rst pulse -> every output 0, state IDLE; a tag 000 stream produces no activity.
2. **Keys and constants:** tag 001 with data0 = R, data1 = 0xA5..A5, then tag 111 with index 0/1 -> aes_key = 0xA5..A5 with no trace of R, key_valid = 1, two label writes at addresses 0 and 1 one cycle later.
3. **Normal cycle:** tag 110 (index1 = 7), then tag 010 beats at indices (0,1), (2,3), (4,5), then tag 011 -> one label write at address 7; three gt_wr_en pulses; gt_count 1→2→3, then 0 after the masks beat; frame_done pulses once; exp_cid = 1; mask = {data0, data1}.
4. **GT order violation:** after gt_count = 2, a tag 010 beat at index0 = 6 -> no write; err = 1, err_code = 3; later beats are ignored.
5. **cid mismatch:** in STREAM with exp_cid = 1, a beat with cid = 0 -> err_code = 4. Illegal tag 100 in a fresh run -> err_code = 1.
6. **Async reset:** rst mid-GT-burst -> immediate clear; a subsequent keys beat is accepted normally.
